instruction_fetch_unit: RTL and testbench

Upstream stage of the 8-bit CPU datapath. Holds a small loadable program memory, a program counter and an instruction register. Runs a fetch/decode sequencer that resolves jumps, conditional branches and halt locally. Issues ALU instructions (3-bit opcode plus 8-bit immediate) to the control_unit/alu_8bit stage over a valid/ready handshake.

---
 rtl/instruction_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch/decode front end: program memory, pc, ir and a sequencer that
// resolves jumps/branches/halt locally. Optional breakpoint logic under IFETCH_BREAKPOINT_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | reading mem[pc] into the read register
// DECODE | latch ir, resolve class (ALU issue, JMP, JZ, HALT)
// ISSUE  | ALU instruction presented, waiting for out_ready
// HALT   | stopped by HALT instruction or breakpoint, waiting for start
module instruction_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              zero_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] pc,
`ifdef IFETCH_BREAKPOINT_EN
  input  logic              brk_en,
  input  logic [ADDR_W-1:0] brk_addr,
  output logic              brk_hit,
`endif
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_JMP  = 2'b01;
  localparam logic [1:0] CLS_JZ   = 2'b10;

  state_t state, state_nx;

  logic [15:0]       mem [2**ADDR_W];
  logic [15:0]       rd_data;
  logic [15:0]       ir, ir_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic              valid_nx;
  logic [2:0]        opcode_nx;
  logic [DATA_W-1:0] imm_nx;
  logic              halted_nx;
  logic              rd_en;
  logic              mem_we;
`ifdef IFETCH_BREAKPOINT_EN
  logic              brk_nx;
`endif

  // Writes are accepted only while the sequencer is parked.
  assign mem_we = prog_we && ((state == S_IDLE) || (state == S_HALT));

  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
    if (rd_en)  rd_data <= mem[pc];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_imm    <= '0;
      halted     <= 1'b0;
`ifdef IFETCH_BREAKPOINT_EN
      brk_hit    <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      ir         <= ir_nx;
      out_valid  <= valid_nx;
      out_opcode <= opcode_nx;
      out_imm    <= imm_nx;
      halted     <= halted_nx;
`ifdef IFETCH_BREAKPOINT_EN
      brk_hit    <= brk_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    valid_nx  = out_valid;
    opcode_nx = out_opcode;
    imm_nx    = out_imm;
    halted_nx = halted;
    rd_en     = 1'b0;
`ifdef IFETCH_BREAKPOINT_EN
    brk_nx    = brk_hit;
`endif
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
`ifdef IFETCH_BREAKPOINT_EN
        if (brk_en && (pc == brk_addr)) begin
          halted_nx = 1'b1;
          brk_nx    = 1'b1;
          state_nx  = S_HALT;
        end else begin
          rd_en    = 1'b1;
          state_nx = S_DECODE;
        end
`else
        rd_en    = 1'b1;
        state_nx = S_DECODE;
`endif
      end
      S_DECODE: begin
        // Decode straight from the read register; ir captures the same word.
        ir_nx = rd_data;
        case (rd_data[12:11])
          CLS_ALU: begin
            opcode_nx = rd_data[15:13];
            imm_nx    = DATA_W'(rd_data[7:0]);
            valid_nx  = 1'b1;
            pc_nx     = pc + 1'b1;
            state_nx  = S_ISSUE;
          end
          CLS_JMP: begin
            pc_nx    = rd_data[ADDR_W-1:0];
            state_nx = S_FETCH;
          end
          CLS_JZ: begin
            pc_nx    = zero_flag ? rd_data[ADDR_W-1:0] : pc + 1'b1;
            state_nx = S_FETCH;
          end
          default: begin
            halted_nx = 1'b1;
            state_nx  = S_HALT;
          end
        endcase
      end
      S_ISSUE: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_nx     = '0;
          halted_nx = 1'b0;
`ifdef IFETCH_BREAKPOINT_EN
          brk_nx    = 1'b0;
`endif
          state_nx  = S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed programs push expected issues,
// a negedge monitor compares every presented instruction against the queue head.
module tb_instruction_fetch_unit;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic          zero_flag = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    out_opcode;
  logic [DW-1:0] out_imm;
  logic [AW-1:0] pc;
  logic          halted;
`ifdef IFETCH_BREAKPOINT_EN
  logic          brk_en = 1'b0;
  logic [AW-1:0] brk_addr = '0;
  logic          brk_hit;
`endif

  int checks = 0;
  int errors = 0;
  logic [10:0] sb [$];

  instruction_fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .zero_flag(zero_flag), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_imm(out_imm), .pc(pc),
`ifdef IFETCH_BREAKPOINT_EN
    .brk_en(brk_en), .brk_addr(brk_addr), .brk_hit(brk_hit),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Every cycle an instruction is presented it must equal the oldest expected issue.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected actual op=%0d imm=%02h required none", out_opcode, out_imm);
      end else begin
        if ({out_opcode, out_imm} !== sb[0]) begin
          errors++;
          $display("FAIL issue_value actual op=%0d imm=%02h required op=%0d imm=%02h",
                   out_opcode, out_imm, sb[0][10:8], sb[0][7:0]);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin tick(); n++; end
    chk(name, 16'(halted), 16'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk(name, 16'(out_valid), 16'd1);
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] imm);
    sb.push_back({op, imm});
  endtask

  initial begin
    #3;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_pc", 16'(pc), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_opcode", 16'(out_opcode), 16'd0);
    chk("rst_imm", 16'(out_imm), 16'd0);
    tick();
    rst = 1'b1;

    // ALU op 1 imm 5 then HALT; valid on the 3rd edge counting the one that samples start
    load(0, 16'h2005);
    load(1, 16'h1800);
    out_ready = 1'b1;
    push(3'd1, 8'h05);
    run_start();
    chk("lat_e1_valid", 16'(out_valid), 16'd0);
    tick();
    chk("lat_e2_valid", 16'(out_valid), 16'd0);
    tick();
    chk("lat_e3_valid", 16'(out_valid), 16'd1);
    tick();
    chk("lat_e4_valid", 16'(out_valid), 16'd0);
    wait_halt("t1_halt");
    chk("t1_pc", 16'(pc), 16'd1);

    // JMP 3 then ALU op 7 imm AA stalled 4 cycles
    load(0, 16'h0803);
    load(3, 16'hE0AA);
    load(4, 16'h1800);
    out_ready = 1'b0;
    push(3'd7, 8'hAA);
    run_start();
    chk("t2_unhalt", 16'(halted), 16'd0);
    wait_valid("t2_valid_wait");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall_valid", 16'(out_valid), 16'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("t2_accept_valid", 16'(out_valid), 16'd0);
    chk("t2_accept_pc", 16'(pc), 16'd4);
    wait_halt("t2_halt");
    chk("t2_halt_pc", 16'(pc), 16'd4);

    // JZ 6 taken and not taken
    load(0, 16'h1006);
    load(1, 16'h1800);
    load(6, 16'h1800);
    zero_flag = 1'b1;
    run_start();
    wait_halt("t3_taken_halt");
    chk("t3_taken_pc", 16'(pc), 16'd6);
    zero_flag = 1'b0;
    run_start();
    wait_halt("t3_untaken_halt");
    chk("t3_untaken_pc", 16'(pc), 16'd1);

    // JZ 15 taken, ALU at 15, pc wraps to 0, JZ re-fetched and now untaken
    load(0, 16'h100F);
    load(15, 16'h4033);
    zero_flag = 1'b1;
    out_ready = 1'b0;
    push(3'd2, 8'h33);
    run_start();
    wait_valid("t4_valid_wait");
    chk("t4_wrap_pc", 16'(pc), 16'd0);
    zero_flag = 1'b0;
    out_ready = 1'b1;
    wait_halt("t4_halt");
    chk("t4_refetch_pc", 16'(pc), 16'd1);

    // write to mem[2] during ISSUE must be dropped; mem[2] stays HALT
    load(0, 16'h6022);
    load(1, 16'h0802);
    load(2, 16'h1800);
    out_ready = 1'b0;
    push(3'd3, 8'h22);
    run_start();
    wait_valid("t5_valid_wait");
    load(2, 16'hA0BB);
    out_ready = 1'b1;
    wait_halt("t5_halt");
    chk("t5_halt_pc", 16'(pc), 16'd2);
    chk("t5_sb_empty", 16'(sb.size()), 16'd0);

    // asynchronous reset while issuing
    out_ready = 1'b0;
    push(3'd3, 8'h22);
    run_start();
    wait_valid("t6_valid_wait");
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 16'(out_valid), 16'd0);
    chk("t6_rst_pc", 16'(pc), 16'd0);
    chk("t6_rst_halted", 16'(halted), 16'd0);
    sb.delete();
    tick();
    rst = 1'b1;

`ifdef IFETCH_BREAKPOINT_EN
    load(0, 16'h2001);
    load(1, 16'h2002);
    load(2, 16'h2003);
    load(3, 16'h1800);
    out_ready = 1'b1;
    brk_en = 1'b1;
    brk_addr = 4'd2;
    push(3'd1, 8'h01);
    push(3'd1, 8'h02);
    run_start();
    wait_halt("brk_halt");
    chk("brk_hit", 16'(brk_hit), 16'd1);
    chk("brk_pc", 16'(pc), 16'd2);
    chk("brk_sb_empty", 16'(sb.size()), 16'd0);
    brk_en = 1'b0;
    push(3'd1, 8'h01);
    push(3'd1, 8'h02);
    push(3'd1, 8'h03);
    run_start();
    chk("brk_clear", 16'(brk_hit), 16'd0);
    chk("brk_resume_pc", 16'(pc), 16'd0);
    wait_halt("brk_resume_halt");
    chk("brk_resume_end_pc", 16'(pc), 16'd3);
`endif

    repeat (3) tick();
    chk("final_sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
